// File: rtl/objective_pkg.sv
// Shared fixed-point types, saturation helper and FSM state type for the
// neuron product unit and its training-side objective block.
package objective_pkg;

  localparam int W = 8;  // fractional bits of the Q8.8 format

  typedef logic signed [15:0] res_t;
  typedef logic signed [23:0] ext_t;

  typedef enum logic [1:0] {
    LOAD,
    FWD,
    DIFF,
    ERR
  } state_t;

  // Clamp a wide value to [-lim, +lim]; the default limit is the full res_t range.
  function automatic res_t sat_res(input ext_t x, input ext_t lim = ext_t'(32767));
    ext_t y;
    if (x > lim) y = lim;
    else if (x < -lim) y = -lim;
    else y = x;
    return y[15:0];
  endfunction

endpackage

// File: rtl/objective.sv
// Objective block: forwards neuron results downstream and, in training mode,
// returns clip((target - result) >>> S) as error. Optional OBJECTIVE_STATS_EN adds loss stats.
module objective
  import objective_pkg::*;
#(
  parameter int S     = 0,
  parameter int LIMIT = 32767
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  input  logic        result_valid,
  input  logic [15:0] result_data,
  output logic        result_ready,
  input  logic        target_valid,
  input  logic [15:0] target_data,
  output logic        target_ready,
  output logic        output_valid,
  output logic [15:0] output_data,
  input  logic        output_ready,
  output logic        error_valid,
  output logic [15:0] error_data,
  input  logic        error_ready
`ifdef OBJECTIVE_STATS_EN
  ,
  output logic [31:0] loss_sum,
  output logic [15:0] loss_count
`endif
);

  state_t      state_q, state_d;
  logic        have_result_q, have_result_d;
  logic        have_target_q, have_target_d;
  logic        train_q, train_d;
  logic        output_valid_q, output_valid_d;
  logic [15:0] output_data_q, output_data_d;
  logic        error_valid_q, error_valid_d;
  logic [15:0] error_data_q, error_data_d;
  res_t        result_q, target_q;
  logic        result_take, target_take;

  ext_t        diff_raw, diff_shift;
  res_t        diff_sat;

  assign diff_raw   = ext_t'(target_q) - ext_t'(result_q);
  assign diff_shift = diff_raw >>> S;
  assign diff_sat   = sat_res(diff_shift, ext_t'(LIMIT));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    have_result_d  = have_result_q;
    have_target_d  = have_target_q;
    train_d        = train_q;
    output_valid_d = output_valid_q;
    output_data_d  = output_data_q;
    error_valid_d  = error_valid_q;
    error_data_d   = error_data_q;
    result_ready   = 1'b0;
    target_ready   = 1'b0;
    result_take    = 1'b0;
    target_take    = 1'b0;

    unique case (state_q)
      LOAD: begin
        result_ready = !have_result_q;
        target_ready = train && !have_target_q;
        result_take  = result_valid && result_ready;
        target_take  = target_valid && target_ready;
        if (result_take) begin
          have_result_d = 1'b1;
          train_d       = train;
        end
        if (target_take) have_target_d = 1'b1;
        // An inference result leaves any captured target in place for later.
        if (have_result_q && (!train_q || have_target_q)) state_d = FWD;
      end
      FWD: begin
        if (!output_valid_q) begin
          output_valid_d = 1'b1;
          output_data_d  = result_q;
        end else if (output_ready) begin
          output_valid_d = 1'b0;
          have_result_d  = 1'b0;
          state_d        = train_q ? DIFF : LOAD;
        end
      end
      DIFF: begin
        error_data_d  = diff_sat;
        error_valid_d = 1'b1;
        have_target_d = 1'b0;
        state_d       = ERR;
      end
      ERR: begin
        if (error_ready) begin
          error_valid_d = 1'b0;
          state_d       = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q        <= LOAD;
      have_result_q  <= 1'b0;
      have_target_q  <= 1'b0;
      train_q        <= 1'b0;
      output_valid_q <= 1'b0;
      output_data_q  <= '0;
      error_valid_q  <= 1'b0;
      error_data_q   <= '0;
    end else begin
      state_q        <= state_d;
      have_result_q  <= have_result_d;
      have_target_q  <= have_target_d;
      train_q        <= train_d;
      output_valid_q <= output_valid_d;
      output_data_q  <= output_data_d;
      error_valid_q  <= error_valid_d;
      error_data_q   <= error_data_d;
    end
  end

  // NOTE: payload registers are not reset; the have_* flags decide whether they hold anything.
  always_ff @(posedge clock) begin
    if (result_take) result_q <= result_data;
    if (target_take) target_q <= target_data;
  end

  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;
  assign error_valid  = error_valid_q;
  assign error_data   = error_data_q;

`ifdef OBJECTIVE_STATS_EN
  logic [31:0] loss_sum_q;
  logic [15:0] loss_count_q;
  logic signed [31:0] sq;
  logic [31:0] sq_term;
  logic [32:0] sum_wide;

  assign sq       = 32'(diff_sat) * 32'(diff_sat);
  assign sq_term  = {8'b0, sq[31:8]};
  assign sum_wide = {1'b0, loss_sum_q} + {1'b0, sq_term};

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_sum_q   <= '0;
      loss_count_q <= '0;
    end else if (state_q == DIFF) begin
      loss_sum_q   <= sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
      loss_count_q <= loss_count_q + 16'd1;
    end
  end

  assign loss_sum   = loss_sum_q;
  assign loss_count = loss_count_q;
`endif

endmodule

// File: tb/tb_objective.sv
// Randomized scoreboard bench for objective: three instances (S=0, S=2, LIMIT=0x1000)
// share one stimulus; a queue-based reference model predicts output and error streams.
module tb_objective;

  localparam int NI = 3;
  localparam int S_TAB   [NI] = '{0, 2, 0};
  localparam int LIM_TAB [NI] = '{32767, 32767, 4096};

  logic        clock;
  logic        reset;
  logic        train;
  logic        result_valid;
  logic [15:0] result_data;
  logic        target_valid;
  logic [15:0] target_data;
  logic        output_ready;
  logic        error_ready;

  logic        r_rdy [NI];
  logic        t_rdy [NI];
  logic        o_vld [NI];
  logic [15:0] o_dat [NI];
  logic        e_vld [NI];
  logic [15:0] e_dat [NI];
`ifdef OBJECTIVE_STATS_EN
  logic [31:0] l_sum [NI];
  logic [15:0] l_cnt [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    objective #(.S(S_TAB[g]), .LIMIT(LIM_TAB[g])) u_dut (
      .clock        (clock),
      .reset        (reset),
      .train        (train),
      .result_valid (result_valid),
      .result_data  (result_data),
      .result_ready (r_rdy[g]),
      .target_valid (target_valid),
      .target_data  (target_data),
      .target_ready (t_rdy[g]),
      .output_valid (o_vld[g]),
      .output_data  (o_dat[g]),
      .output_ready (output_ready),
      .error_valid  (e_vld[g]),
      .error_data   (e_dat[g]),
      .error_ready  (error_ready)
`ifdef OBJECTIVE_STATS_EN
      ,
      .loss_sum     (l_sum[g]),
      .loss_count   (l_cnt[g])
`endif
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h at %0t", name, act, $time);
  endtask

  // Reference: error = clamp((target - result) >>> s, -lim, +lim) in plain integers.
  function automatic logic [15:0] exp_error(input logic [15:0] t, input logic [15:0] r,
                                            input int s, input int lim);
    int d;
    d = int'($signed(t)) - int'($signed(r));
    d = d >>> s;
    if (d > lim) d = lim;
    if (d < -lim) d = -lim;
    return d[15:0];
  endfunction

  logic [15:0] exp_out_q [$];
  logic [47:0] exp_err_q [$];
  logic [15:0] tgt_q     [$];
  logic [15:0] pend_q    [$];

  // Model: watches input transfers, pairs training results with targets in order.
  always @(negedge clock) begin
    logic [15:0] t, r;
    logic [47:0] e;
    if (reset) begin
      exp_out_q.delete();
      exp_err_q.delete();
      tgt_q.delete();
      pend_q.delete();
    end else begin
      if (target_valid && t_rdy[0]) tgt_q.push_back(target_data);
      if (result_valid && r_rdy[0]) begin
        exp_out_q.push_back(result_data);
        if (train) pend_q.push_back(result_data);
      end
      while (pend_q.size() > 0 && tgt_q.size() > 0) begin
        t = tgt_q.pop_front();
        r = pend_q.pop_front();
        for (int i = 0; i < NI; i++) e[i*16 +: 16] = exp_error(t, r, S_TAB[i], LIM_TAB[i]);
        exp_err_q.push_back(e);
      end
    end
  end

  // Monitor: pops expectations on each output/error transfer, checks hold-while-stalled.
  bit          o_stall, e_stall;
  logic [15:0] o_prev, e_prev;
  always @(negedge clock) begin
    logic [15:0] eo;
    logic [47:0] ee;
    if (reset) begin
      o_stall = 1'b0;
      e_stall = 1'b0;
    end else begin
      if (o_stall) begin
        check("out_hold_valid", 32'(o_vld[0]), 32'd1);
        check("out_hold_data", 32'(o_dat[0]), 32'(o_prev));
      end
      if (e_stall) begin
        check("err_hold_valid", 32'(e_vld[0]), 32'd1);
        check("err_hold_data", 32'(e_dat[0]), 32'(e_prev));
      end
      if (o_vld[0] && output_ready) begin
        if (exp_out_q.size() == 0) fail("out_unexpected", 32'(o_dat[0]));
        else begin
          eo = exp_out_q.pop_front();
          for (int i = 0; i < NI; i++) begin
            check($sformatf("out_valid[%0d]", i), 32'(o_vld[i]), 32'd1);
            check($sformatf("out_data[%0d]", i), 32'(o_dat[i]), 32'(eo));
          end
        end
      end
      if (e_vld[0] && error_ready) begin
        if (exp_err_q.size() == 0) fail("err_unexpected", 32'(e_dat[0]));
        else begin
          ee = exp_err_q.pop_front();
          for (int i = 0; i < NI; i++) begin
            check($sformatf("err_valid[%0d]", i), 32'(e_vld[i]), 32'd1);
            check($sformatf("err_data[%0d]", i), 32'(e_dat[i]), 32'(ee[i*16 +: 16]));
          end
        end
      end
      o_stall = o_vld[0] && !output_ready;
      e_stall = e_vld[0] && !error_ready;
      o_prev  = o_dat[0];
      e_prev  = e_dat[0];
    end
  end

  // Downstream readies: random when rdy_auto, otherwise the forced levels.
  bit rdy_auto, out_force, err_force;
  initial begin
    output_ready = 1'b0;
    error_ready  = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      output_ready = rdy_auto ? (($urandom % 4) != 0) : out_force;
      error_ready  = rdy_auto ? (($urandom % 3) != 0) : err_force;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_result(input logic [15:0] d);
    int n = 0;
    result_valid = 1'b1;
    result_data  = d;
    while (1) begin
      @(negedge clock);
      if (r_rdy[0]) break;
      n++;
      if (n > 1000) begin
        fail("result_timeout", 32'(d));
        break;
      end
    end
    @(posedge clock);
    #1;
    result_valid = 1'b0;
  endtask

  task automatic send_target(input logic [15:0] d);
    int n = 0;
    target_valid = 1'b1;
    target_data  = d;
    while (1) begin
      @(negedge clock);
      if (t_rdy[0]) break;
      n++;
      if (n > 1000) begin
        fail("target_timeout", 32'(d));
        break;
      end
    end
    @(posedge clock);
    #1;
    target_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] r, input logic [15:0] t);
    fork
      send_result(r);
      send_target(t);
    join
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_out_q.size() + exp_err_q.size() + pend_q.size()) != 0 && n < 2000) begin
      cycles(1);
      n++;
    end
    if (n >= 2000) fail("idle_timeout", 32'(exp_out_q.size() + exp_err_q.size()));
    cycles(2);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom % 6)
      0: v = 16'h8000;
      1: v = 16'h7FFF;
      2: v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int n;
    reset        = 1'b1;
    train        = 1'b0;
    result_valid = 1'b0;
    result_data  = '0;
    target_valid = 1'b0;
    target_data  = '0;
    rdy_auto     = 1'b0;
    out_force    = 1'b1;
    err_force    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check("rst_out_valid", 32'(o_vld[i]), 32'd0);
      check("rst_err_valid", 32'(e_vld[i]), 32'd0);
      check("rst_out_data", 32'(o_dat[i]), 32'd0);
      check("rst_err_data", 32'(e_dat[i]), 32'd0);
      check("rst_result_ready", 32'(r_rdy[i]), 32'd1);
      check("rst_target_ready", 32'(t_rdy[i]), 32'd0);
    end
    @(posedge clock);
    #1;

    // Inference: output two cycles after the result transfer, no error, no target accept.
    train = 1'b0;
    send_result(16'h0180);
    n = 0;
    while (1) begin
      @(negedge clock);
      check("infer_target_ready", 32'(t_rdy[0]), 32'd0);
      if (o_vld[0] || n > 20) break;
      n++;
    end
    check("infer_latency", 32'(n), 32'd2);
    @(posedge clock);
    #1;
    wait_idle();

    // Directed training pairs: plain difference, negative shift, clip.
    train = 1'b1;
    send_pair(16'h0100, 16'h0300);
    wait_idle();
    send_pair(16'h0400, 16'h0000);
    wait_idle();
    send_pair(16'h8000, 16'h7FFF);
    wait_idle();

    // A target captured before an inference result is kept for the next training result.
    send_target(16'h0200);
    train = 1'b0;
    send_result(16'h0010);
    train = 1'b1;
    send_result(16'h0100);
    wait_idle();

    // Target 5 cycles ahead of result, then stalled output and error handshakes.
    out_force = 1'b0;
    err_force = 1'b0;
    send_target(16'h0123);
    cycles(4);
    send_result(16'h0456);
    n = 0;
    while (!o_vld[0] && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(3);
    out_force = 1'b1;
    n = 0;
    while (!e_vld[0] && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(4);
    err_force = 1'b1;
    wait_idle();

    // Reset while an error is pending; then reset with a captured target, then a fresh pair.
    err_force = 1'b0;
    send_pair(16'h0010, 16'h0020);
    n = 0;
    while (!e_vld[0] && n < 100) begin
      cycles(1);
      n++;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check("rst_mid_err_valid", 32'(e_vld[i]), 32'd0);
      check("rst_mid_out_valid", 32'(o_vld[i]), 32'd0);
    end
    @(posedge clock);
    #1;
    err_force = 1'b1;
    send_target(16'h0777);
    reset_pulse();
    send_pair(16'h0100, 16'h0180);
    wait_idle();

    // Randomized mix of inference and training with random downstream backpressure.
    rdy_auto = 1'b1;
    for (int it = 0; it < 60; it++) begin
      logic [15:0] r, t;
      int k1, k2;
      r  = pick();
      t  = pick();
      k1 = $urandom % 4;
      k2 = $urandom % 4;
      train = 1'($urandom % 2);
      if (train) begin
        fork
          begin cycles(k1); send_result(r); end
          begin cycles(k2); send_target(t); end
        join
      end else begin
        send_result(r);
      end
    end
    wait_idle();

    check("scoreboard_empty",
          32'(exp_out_q.size() + exp_err_q.size() + pend_q.size() + tgt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
